alu_nibble_seq: RTL and testbench

Multi-cycle sequencer that executes wide (4*NIBBLES-bit) ADD/SUB/AND/OR operations on one shared `alu_4bit` instance, one nibble per clock, least significant nibble first, chaining carry between nibbles. It sits between a requester with a valid/ready operand interface and the existing 4-bit ALU datapath. It lets the design reach wide arithmetic without replicating ALU slices.

---
 rtl/alu_nibble_seq_pkg.sv | 25 ++
 rtl/alu_4bit.sv | 24 ++
 rtl/alu_nibble_seq.sv | 120 ++++++++++++
 tb/tb_alu_nibble_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_nibble_seq_pkg.sv
// Shared opcodes, sequencer state encoding and carry-seed helper for the
// nibble-serial wide ALU.
package alu_nibble_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SUB seeds a 1 so that A + ~B + 1 forms the two's complement difference.
  function automatic logic initial_carry(input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  initial_carry = cin;
      OP_SUB:  initial_carry = 1'b1;
      default: initial_carry = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_4bit.sv
// Existing 4-bit ALU slice: ADD/SUB with carry chain, bitwise AND/OR.
module alu_4bit
  import alu_nibble_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] opcode,
  input  logic       cin,
  output logic [3:0] result,
  output logic       cout
);

  always_comb begin
    result = 4'h0;
    cout   = 1'b0;
    case (opcode)
      OP_ADD:  {cout, result} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      OP_SUB:  {cout, result} = {1'b0, a} + {1'b0, ~b} + {4'b0000, cin};
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Wide ADD/SUB/AND/OR built by streaming nibbles, LSB first, through one
// shared alu_4bit with the carry held in a register between nibbles.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [1:0]           in_op,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_cout,
  output logic                 out_zero
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_valid;
  logic            r_zero;

  logic [3:0]   w_a_nib;
  logic [3:0]   w_b_nib;
  logic [1:0]   w_alu_op;
  logic [3:0]   w_alu_res;
  logic         w_alu_cout;
  logic         w_carry_next;
  logic [W-1:0] w_result_next;

  // SUB runs through the ALU as an ADD of the inverted B nibble.
  assign w_a_nib  = r_a[4*r_idx +: 4];
  assign w_b_nib  = (r_op == OP_SUB) ? ~r_b[4*r_idx +: 4] : r_b[4*r_idx +: 4];
  assign w_alu_op = (r_op == OP_SUB) ? OP_ADD : r_op;

  alu_4bit u_alu (
    .a      (w_a_nib),
    .b      (w_b_nib),
    .opcode (w_alu_op),
    .cin    (r_carry),
    .result (w_alu_res),
    .cout   (w_alu_cout)
  );

  always_comb begin
    w_carry_next  = (r_op == OP_AND || r_op == OP_OR) ? 1'b0 : w_alu_cout;
    w_result_next = r_result;
    w_result_next[4*r_idx +: 4] = w_alu_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_valid  <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_op;
            r_carry <= initial_carry(in_op, in_cin);
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result <= w_result_next;
          r_carry  <= w_carry_next;
          r_cout   <= w_carry_next;
          r_zero   <= (w_result_next == '0);
          // The index parks on the last nibble rather than wrapping.
          if (r_idx == LAST_IDX) begin
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_cout   = r_cout;
  assign out_zero   = r_zero;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed corner cases, random
// operations against an arithmetic reference, backpressure, reset abort.
module tb_alu_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_op = 2'b00;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         out_zero;

  int vectors = 0;
  int miscompares = 0;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_cin     (in_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  // Returns {cout, result} straight from the arithmetic definition.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op, input logic cin);
    case (op)
      2'b00:   ref_op = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      2'b01:   ref_op = {(a >= b), W'(a - b)};
      2'b10:   ref_op = {1'b0, a & b};
      default: ref_op = {1'b0, a | b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits for out_valid; lat counts edges after accept.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin,
                          output int lat, output bit tmo);
    int n;
    n = 0;
    lat = -1;
    tmo = 1'b0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin tmo = 1'b1; return; end
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) tmo = 1'b1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_cout !== 1'b0 || out_zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got v=%b r=%h c=%b z=%b expected v=0 r=0000 c=0 z=1",
               out_valid, out_result, out_cout, out_zero);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [9] = '{16'h0FFF, 16'hFFFF, 16'h0000, 16'h1000, 16'h0000, 16'h1234, 16'h1234, 16'hA5A5, 16'hA5A5};
    logic [W-1:0] tb [9] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h1234, 16'h1234, 16'h0FF0, 16'h0FF0};
    logic [1:0]   top[9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
    logic         tci[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] er [9] = '{16'h1000, 16'h0000, 16'h0001, 16'h0FFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h05A0, 16'hAFF5};
    logic         ec [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    bit tmo;
    for (int i = 0; i < 9; i++) begin
      drive_op(ta[i], tb[i], top[i], tci[i], lat, tmo);
      vectors++;
      if (tmo || lat != NIB) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_latency got %0d (timeout=%b) expected %0d", i, lat, tmo, NIB);
      end
      vectors++;
      if (out_result !== er[i] || out_cout !== ec[i] || out_zero !== (er[i] == '0)) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_result got r=%h c=%b z=%b expected r=%h c=%b z=%b",
                 i, out_result, out_cout, out_zero, er[i], ec[i], (er[i] == '0));
      end
      release_result();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_handshake got v=%b rdy=%b expected v=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         cin;
    logic [W:0]   exp;
    int lat;
    bit tmo;
    for (int i = 0; i < 30; i++) begin
      a   = W'($urandom);
      b   = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
      op  = 2'($urandom);
      cin = 1'($urandom);
      exp = ref_op(a, b, op, cin);
      drive_op(a, b, op, cin, lat, tmo);
      vectors++;
      if (tmo || out_result !== exp[W-1:0] || out_cout !== exp[W] || out_zero !== (exp[W-1:0] == '0)) begin
        miscompares++;
        $display("[TB] FAIL random%0d op=%0d a=%h b=%h cin=%b got r=%h c=%b z=%b (timeout=%b) expected r=%h c=%b z=%b",
                 i, op, a, b, cin, out_result, out_cout, out_zero, tmo, exp[W-1:0], exp[W], (exp[W-1:0] == '0));
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    int lat;
    bit tmo;
    exp = ref_op(16'hBEEF, 16'h1234, 2'b00, 1'b1);
    drive_op(16'hBEEF, 16'h1234, 2'b00, 1'b1, lat, tmo);
    in_a = 16'h0F0F; in_b = 16'h0101; in_op = 2'b11; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (tmo || out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp[W-1:0] || out_cout !== exp[W]) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold%0d got v=%b rdy=%b r=%h c=%b expected v=1 rdy=0 r=%h c=%b",
                 i, out_valid, in_ready, out_result, out_cout, exp[W-1:0], exp[W]);
      end
    end
    in_valid = 1'b0;
    release_result();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_ignored_request got out_valid=%b expected 0", out_valid);
    end
    exp = ref_op(16'h8000, 16'h8001, 2'b01, 1'b0);
    drive_op(16'h8000, 16'h8001, 2'b01, 1'b0, lat, tmo);
    vectors++;
    if (tmo || out_result !== exp[W-1:0] || out_cout !== exp[W]) begin
      miscompares++;
      $display("[TB] FAIL backpressure_next got r=%h c=%b (timeout=%b) expected r=%h c=%b",
               out_result, out_cout, tmo, exp[W-1:0], exp[W]);
    end
    release_result();
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit tmo;
    bit seen;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 2'b00; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== '0 || out_zero !== 1'b1 || out_cout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset got rdy=%b v=%b r=%h z=%b c=%b expected rdy=0 v=0 r=0000 z=1 c=0",
               in_ready, out_valid, out_result, out_zero, out_cout);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrun_abort got out_valid_seen=%b rdy=%b expected 0 and 1", seen, in_ready);
    end
    drive_op(16'h00FF, 16'h0001, 2'b00, 1'b0, lat, tmo);
    vectors++;
    if (tmo || out_result !== 16'h0100 || out_cout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_add got r=%h c=%b (timeout=%b) expected r=0100 c=0", out_result, out_cout, tmo);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] exp;
    int last;
    int nacc;
    bit acc;
    last = -1;
    nacc = 0;
    out_ready = 1'b1;
    in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom); in_cin = 1'($urandom);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL b2b_spurious_valid at cycle %0d got out_valid=1 expected 0", cyc);
        end else begin
          exp = q.pop_front();
          if (out_result !== exp[W-1:0] || out_cout !== exp[W]) begin
            miscompares++;
            $display("[TB] FAIL b2b_result cycle %0d got r=%h c=%b expected r=%h c=%b",
                     cyc, out_result, out_cout, exp[W-1:0], exp[W]);
          end
        end
      end
      acc = in_ready && in_valid;
      if (acc) begin
        q.push_back(ref_op(in_a, in_b, in_op, in_cin));
        if (last >= 0) begin
          vectors++;
          if (cyc - last != NIB + 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_interval got %0d expected %0d", cyc - last, NIB + 2);
          end
        end
        last = cyc;
        nacc++;
      end
      tick();
      if (acc) begin
        in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom); in_cin = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3 * NIB && q.size() != 0; i++) begin
      if (out_valid) begin
        exp = q.pop_front();
        vectors++;
        if (out_result !== exp[W-1:0] || out_cout !== exp[W]) begin
          miscompares++;
          $display("[TB] FAIL b2b_drain got r=%h c=%b expected r=%h c=%b", out_result, out_cout, exp[W-1:0], exp[W]);
        end
      end
      tick();
    end
    vectors++;
    if (q.size() != 0 || nacc < 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_completion got pending=%0d accepted=%0d expected 0 and >=5", q.size(), nacc);
    end
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
